// File: rtl/snake_input_ctrl.sv
// Button conditioning and turn arbitration for the VGA snake game core.
// Optional: define SNAKE_INPUT_QUEUE_EN for a 2-entry turn FIFO instead of a single last-wins register.
module snake_input_ctrl #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] btn_raw,
   input  logic       tick,
   output logic [3:0] btn_db,
   output logic [1:0] dir,
   output logic       dir_changed
);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [3:0]       sync_1;
   logic [3:0]       btn_sync;
   logic [3:0]       btn_db_q;
   logic [3:0]       press;
   logic [CNT_W-1:0] db_cnt [4];
   logic             cand_valid;
   logic [1:0]       cand;
   logic [1:0]       ref_dir;
   logic [1:0]       dir_next;
   logic             commit;
   logic             commit_q;
   logic             accept;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_1   <= '0;
         btn_sync <= '0;
      end else begin
         sync_1   <= btn_raw;
         btn_sync <= sync_1;
      end
   end

   // A bit flips only after its synchronised value has disagreed for a full window.
   always_ff @(posedge clk) begin
      if (reset) begin
         btn_db   <= '0;
         btn_db_q <= '0;
         for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
      end else begin
         btn_db_q <= btn_db;
         for (int i = 0; i < 4; i++) begin
            if (btn_sync[i] == btn_db[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == CNT_LAST) begin
               btn_db[i] <= ~btn_db[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   always_comb begin
      press      = btn_db & ~btn_db_q;
      cand_valid = |press;
      cand       = 2'd0;
      if (press[0])      cand = 2'd0;
      else if (press[1]) cand = 2'd1;
      else if (press[2]) cand = 2'd2;
      else if (press[3]) cand = 2'd3;
   end

`ifdef SNAKE_INPUT_QUEUE_EN
   logic [1:0] fifo_0, fifo_1, fifo_0_pop, fifo_0_next, fifo_1_next;
   logic [1:0] fifo_cnt, fifo_cnt_pop, fifo_cnt_next;

   // New turns are judged against the newest queued turn, after this tick's pop.
   always_comb begin
      commit       = tick && (fifo_cnt != 2'd0);
      fifo_0_pop   = commit ? fifo_1 : fifo_0;
      fifo_cnt_pop = commit ? 2'(fifo_cnt - 2'd1) : fifo_cnt;
      dir_next     = commit ? fifo_0 : dir;
      if (fifo_cnt_pop == 2'd0)      ref_dir = dir_next;
      else if (fifo_cnt_pop == 2'd1) ref_dir = fifo_0_pop;
      else                           ref_dir = fifo_1;
      accept        = cand_valid && (cand != ref_dir) && (cand != (ref_dir ^ 2'd2));
      fifo_0_next   = fifo_0_pop;
      fifo_1_next   = fifo_1;
      fifo_cnt_next = fifo_cnt_pop;
      if (accept) begin
         if (fifo_cnt_pop == 2'd0) begin
            fifo_0_next   = cand;
            fifo_cnt_next = 2'd1;
         end else begin
            fifo_1_next   = cand;
            fifo_cnt_next = 2'd2;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fifo_0   <= '0;
         fifo_1   <= '0;
         fifo_cnt <= '0;
      end else begin
         fifo_0   <= fifo_0_next;
         fifo_1   <= fifo_1_next;
         fifo_cnt <= fifo_cnt_next;
      end
   end
`else
   logic [1:0] pending, pending_next;
   logic       pending_valid, pending_valid_next;

   // On a committing tick the pending turn becomes the reference for the new press.
   always_comb begin
      commit             = tick && pending_valid;
      ref_dir            = commit ? pending : dir;
      dir_next           = commit ? pending : dir;
      accept             = cand_valid && (cand != ref_dir) && (cand != (ref_dir ^ 2'd2));
      pending_next       = pending;
      pending_valid_next = pending_valid;
      if (accept) begin
         pending_next       = cand;
         pending_valid_next = 1'b1;
      end else if (commit) begin
         pending_valid_next = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pending       <= '0;
         pending_valid <= 1'b0;
      end else begin
         pending       <= pending_next;
         pending_valid <= pending_valid_next;
      end
   end
`endif

   // The change pulse trails the direction update by one cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         dir         <= 2'd1;
         commit_q    <= 1'b0;
         dir_changed <= 1'b0;
      end else begin
         dir         <= dir_next;
         commit_q    <= commit;
         dir_changed <= commit_q;
      end
   end
endmodule

// File: tb/tb_snake_input_ctrl.sv
// Randomised self-checking bench for snake_input_ctrl against a behavioural model.
module tb_snake_input_ctrl;
   localparam int DB = 4;
`ifdef SNAKE_INPUT_QUEUE_EN
   localparam int QDEPTH = 2;
   localparam bit QMODE  = 1'b1;
`else
   localparam int QDEPTH = 1;
   localparam bit QMODE  = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] btn_raw = 4'd0;
   logic       tick = 1'b0;
   logic [3:0] btn_db;
   logic [1:0] dir;
   logic       dir_changed;

   always #5 clk = ~clk;

   snake_input_ctrl #(.DEBOUNCE_CYCLES(DB)) dut (
      .clk(clk),
      .reset(reset),
      .btn_raw(btn_raw),
      .tick(tick),
      .btn_db(btn_db),
      .dir(dir),
      .dir_changed(dir_changed)
   );

   int n_cmp = 0;
   int n_fail = 0;
   int cycle = 0;

   // Model: raw delayed two edges, a window of the last DB synced samples, and a turn queue.
   logic [3:0] m_s1, m_s2, m_db, m_db_prev;
   logic [3:0] m_hist [DB];
   logic [1:0] m_dir;
   logic       m_commit_q, m_dc;
   logic [1:0] m_q [$];

   task automatic modelReset();
      m_s1 = '0; m_s2 = '0; m_db = '0; m_db_prev = '0;
      for (int k = 0; k < DB; k++) m_hist[k] = '0;
      m_dir = 2'd1; m_commit_q = 1'b0; m_dc = 1'b0;
      m_q.delete();
   endtask

   task automatic modelStep();
      logic [3:0] pr;
      logic [1:0] cnd, refd;
      bit all_diff;
      if (reset) begin
         modelReset();
         return;
      end
      pr  = m_db & ~m_db_prev;
      cnd = 2'd0;
      for (int i = 3; i >= 0; i--) if (pr[i]) cnd = 2'(i);
      m_dc = m_commit_q;
      m_commit_q = tick && (m_q.size() > 0);
      if (m_commit_q) m_dir = m_q.pop_front();
      if (pr != 4'd0) begin
         refd = (QMODE && m_q.size() > 0) ? m_q[m_q.size()-1] : m_dir;
         if (cnd != refd && cnd != (refd ^ 2'd2)) begin
            if (m_q.size() < QDEPTH) m_q.push_back(cnd);
            else m_q[m_q.size()-1] = cnd;
         end
      end
      m_db_prev = m_db;
      for (int k = DB - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = m_s2;
      for (int b = 0; b < 4; b++) begin
         all_diff = 1'b1;
         for (int k = 0; k < DB; k++) if (m_hist[k][b] == m_db[b]) all_diff = 1'b0;
         if (all_diff) m_db[b] = ~m_db[b];
      end
      m_s2 = m_s1;
      m_s1 = btn_raw;
   endtask

   task automatic compare(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cycle, act, exp);
      end
   endtask

   task automatic checkOutput();
      compare("btn_db", btn_db, m_db);
      compare("dir", {2'b00, dir}, {2'b00, m_dir});
      compare("dir_changed", {3'b000, dir_changed}, {3'b000, m_dc});
   endtask

   task automatic applyStimulus(input logic [3:0] raw, input logic tk, input logic rst);
      @(negedge clk);
      btn_raw = raw;
      tick    = tk;
      reset   = rst;
      @(posedge clk);
      modelStep();
      #1;
      cycle++;
      checkOutput();
   endtask

   initial begin
      logic [3:0] raw;
      logic       tk, rst;

      applyStimulus(4'd0, 1'b0, 1'b1);
      applyStimulus(4'd0, 1'b0, 1'b1);
      compare("reset_dir", {2'b00, dir}, 4'd1);
      compare("reset_btn_db", btn_db, 4'd0);
      compare("reset_dir_changed", {3'b000, dir_changed}, 4'd0);
      applyStimulus(4'd0, 1'b1, 1'b0);
      applyStimulus(4'd0, 1'b0, 1'b0);
      applyStimulus(4'd0, 1'b0, 1'b0);
      compare("idle_tick_dir", {2'b00, dir}, 4'd1);
      compare("idle_tick_pulse", {3'b000, dir_changed}, 4'd0);

      for (int k = 1; k <= 6; k++) begin
         applyStimulus(4'b0001, 1'b0, 1'b0);
         compare("latency_btn_db0", {3'b000, btn_db[0]}, (k == 6) ? 4'd1 : 4'd0);
      end
      applyStimulus(4'b0001, 1'b0, 1'b0);
      compare("up_pending_dir", {2'b00, dir}, 4'd1);
      applyStimulus(4'b0001, 1'b1, 1'b0);
      compare("up_commit_dir", {2'b00, dir}, 4'd0);
      compare("up_commit_nopulse", {3'b000, dir_changed}, 4'd0);
      applyStimulus(4'b0001, 1'b0, 1'b0);
      compare("up_pulse_on", {3'b000, dir_changed}, 4'd1);
      applyStimulus(4'b0001, 1'b0, 1'b0);
      compare("up_pulse_off", {3'b000, dir_changed}, 4'd0);

      applyStimulus(4'd0, 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) applyStimulus(4'b0100, 1'b0, 1'b0);
      for (int k = 0; k < 8; k++) begin
         applyStimulus(4'd0, 1'b0, 1'b0);
         compare("glitch_btn_db", btn_db, 4'd0);
      end
      applyStimulus(4'd0, 1'b1, 1'b0);
      compare("glitch_dir", {2'b00, dir}, 4'd1);

      for (int k = 0; k < 8; k++) applyStimulus(4'b1000, 1'b0, 1'b0);
      applyStimulus(4'b1000, 1'b1, 1'b0);
      applyStimulus(4'b1000, 1'b0, 1'b0);
      compare("reversal_dir", {2'b00, dir}, 4'd1);
      compare("reversal_nopulse", {3'b000, dir_changed}, 4'd0);
      for (int k = 0; k < 8; k++) applyStimulus(4'd0, 1'b0, 1'b0);

      for (int k = 0; k < 8; k++) applyStimulus(4'b0101, 1'b0, 1'b0);
      applyStimulus(4'b0101, 1'b1, 1'b0);
      compare("priority_dir", {2'b00, dir}, 4'd0);
      for (int k = 0; k < 8; k++) applyStimulus(4'd0, 1'b0, 1'b0);

      raw = 4'd0;
      for (int n = 0; n < 5000; n++) begin
         if ($urandom_range(0, 5) == 0) raw = raw ^ (4'b0001 << $urandom_range(0, 3));
         if ($urandom_range(0, 40) == 0) raw = 4'd0;
         tk  = ($urandom_range(0, 4) == 0);
         rst = ($urandom_range(0, 599) == 0);
         applyStimulus(raw, tk, rst);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
